rmii_tx_framer: RTL

RMII_TX_FRAMER -- requirements
Module: rmii_tx_framer

---
 rtl/rmii_pkg.sv | 28 ++
 rtl/rmii_tx_framer_if.sv | 28 ++
 rtl/crc32_d8.sv | 22 ++
 rtl/rmii_tx_framer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/rmii_pkg.sv
// Shared state encoding, framing constants and FCS byte helper for the RMII transmit path.
// Pure definitions: no latency, no handshake.
// Imported by every RMII TX file.
package rmii_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        PLD,
        FCS,
        IFG
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam int unsigned PRE_LEN       = 7;

    // FCS goes out complemented, least significant byte first.
    function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
        logic [31:0] fcs;
        fcs = ~crc;
        return fcs[8*idx +: 8];
    endfunction

endpackage

// File: rtl/rmii_tx_framer_if.sv
// Payload-source, serializer and status signals of the RMII transmit framer.
// No logic: master is the frame requester/payload source/serializer, slave is the framer.
// Flow control: I_save strobes byte consumption, O_pld_rd pops the FWFT payload source.
interface rmii_tx_framer_if;
    import rmii_pkg::*;

    logic        I_start;
    logic [10:0] I_len;
    logic [7:0]  I_pld_data;
    logic        I_pld_valid;
    logic        O_pld_rd;
    logic        I_save;
    logic        O_txen;
    logic [7:0]  O_data;
    logic        O_busy;
    logic        O_underrun;

    modport master (
        output I_start, I_len, I_pld_data, I_pld_valid, I_save,
        input  O_pld_rd, O_txen, O_data, O_busy, O_underrun
    );

    modport slave (
        input  I_start, I_len, I_pld_data, I_pld_valid, I_save,
        output O_pld_rd, O_txen, O_data, O_busy, O_underrun
    );

endinterface

// File: rtl/crc32_d8.sv
// Next-state CRC-32 (reflected polynomial) for one data byte.
// Latency: purely combinational, zero cycles.
// No backpressure: caller decides when to register the result.
module crc32_d8
    import rmii_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_w;

    always_comb begin
        crc_w = crc_i ^ {24'h000000, data_i};
        for (int b = 0; b < 8; b++) begin
            crc_w = crc_w[0] ? ((crc_w >> 1) ^ CRC_POLY) : (crc_w >> 1);
        end
        crc_o = crc_w;
    end

endmodule

// File: rtl/rmii_tx_framer.sv
// Byte-level RMII frame builder: preamble, SFD, payload, optional FCS (RMII_TX_CRC_EN), then IFG.
// Latency: start accepted -> O_txen/0x55 next edge; each I_save -> next byte the following cycle.
// Backpressure: serializer paces bytes with I_save; an empty payload source yields 0x00 and a sticky underrun.
module rmii_tx_framer
    import rmii_pkg::*;
#(
    parameter int unsigned MAX_LEN    = 1500,
    parameter int unsigned IFG_CYCLES = 48
) (
    input  logic              I_clk50m,
    input  logic              I_rst,
    rmii_tx_framer_if.slave   bus
);

    localparam int unsigned IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    state_t             state_q;
    logic [7:0]         data_q;
    logic               txen_q;
    logic               busy_q;
    logic               rd_q;
    logic               unr_q;
    logic [10:0]        len_q;
    logic [10:0]        idx_q;
    logic [2:0]         cnt_q;
    logic [IFG_W-1:0]   ifg_q;

    logic               start_ok_d;
    logic [7:0]         pld_byte_d;
    logic               last_pld_d;

    assign start_ok_d = bus.I_start && (bus.I_len != 11'd0)
                        && ({21'd0, bus.I_len} <= MAX_LEN);
    assign pld_byte_d = bus.I_pld_valid ? bus.I_pld_data : 8'h00;
    assign last_pld_d = (state_q == PLD) && (idx_q == len_q);

`ifdef RMII_TX_CRC_EN
    logic [31:0] crc_q;
    logic [31:0] crc_d;

    crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (pld_byte_d),
        .crc_o  (crc_d)
    );
`endif

    always_ff @(posedge I_clk50m) begin
        if (I_rst) begin
            state_q <= IDLE;
            data_q  <= 8'h00;
            txen_q  <= 1'b0;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
            unr_q   <= 1'b0;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ifg_q   <= '0;
`ifdef RMII_TX_CRC_EN
            crc_q   <= CRC_INIT;
`endif
        end else begin
            rd_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok_d) begin
                        len_q   <= bus.I_len;
                        data_q  <= PREAMBLE_BYTE;
                        txen_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        unr_q   <= 1'b0;
                        cnt_q   <= 3'd1;
                        idx_q   <= '0;
`ifdef RMII_TX_CRC_EN
                        crc_q   <= CRC_INIT;
`endif
                        state_q <= PRE;
                    end
                end
                PRE: begin
                    if (bus.I_save) begin
                        if (cnt_q == 3'(PRE_LEN)) begin
                            data_q  <= SFD_BYTE;
                            state_q <= SFD;
                        end else begin
                            data_q <= PREAMBLE_BYTE;
                            cnt_q  <= cnt_q + 3'd1;
                        end
                    end
                end
                SFD, PLD: begin
                    if (bus.I_save) begin
                        if (last_pld_d) begin
`ifdef RMII_TX_CRC_EN
                            data_q  <= fcs_byte(crc_q, 2'd0);
                            cnt_q   <= 3'd1;
                            state_q <= FCS;
`else
                            txen_q  <= 1'b0;
                            data_q  <= 8'h00;
                            ifg_q   <= '0;
                            state_q <= IFG;
`endif
                        end else begin
                            // A starved load still consumes a byte slot so the frame length holds.
                            data_q  <= pld_byte_d;
                            rd_q    <= bus.I_pld_valid;
                            unr_q   <= unr_q | ~bus.I_pld_valid;
                            idx_q   <= idx_q + 11'd1;
`ifdef RMII_TX_CRC_EN
                            crc_q   <= crc_d;
`endif
                            state_q <= PLD;
                        end
                    end
                end
`ifdef RMII_TX_CRC_EN
                FCS: begin
                    if (bus.I_save) begin
                        if (cnt_q == 3'd4) begin
                            txen_q  <= 1'b0;
                            data_q  <= 8'h00;
                            ifg_q   <= '0;
                            state_q <= IFG;
                        end else begin
                            data_q <= fcs_byte(crc_q, cnt_q[1:0]);
                            cnt_q  <= cnt_q + 3'd1;
                        end
                    end
                end
`endif
                IFG: begin
                    if (ifg_q == IFG_W'(IFG_CYCLES - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        ifg_q <= ifg_q + 1'b1;
                    end
                end
                default: begin
                    txen_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.O_txen     = txen_q;
    assign bus.O_data     = data_q;
    assign bus.O_busy     = busy_q;
    assign bus.O_pld_rd   = rd_q;
    assign bus.O_underrun = unr_q;

endmodule
